text_banner_ctrl: RTL and testbench
===================================

Name: text_banner_ctrl

Overview:
Sequences the shared character-glyph renderer for a single-row text banner of up to NUM_CHARS characters, such as "PRESS START" or "P1 WINS".
- On each pixel tick, locates the character slot under the current scan position (x, y).
- Drives the glyph renderer's start_x/start_y and character code for that slot.
- Applies frame-synchronous display modes: hide, show, blink and horizontal scroll.
- Sits between the VGA timing generator and the glyph renderer; its output is ORed into the pixel mux.

Parameters:
NUM_CHARS, 8, number of character slots (power of two).
CHAR_H, 40, glyph height in pixels.
PITCH, 32, horizontal slot pitch in pixels (power of two; glyph width 26 plus 6 gap).
H_RES, 640, visible line width; scroll wrap target.
BLINK_FRAMES, 30, frames per blink half-period.
SCROLL_STEP, 2, pixels moved left per frame in SCROLL mode.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_tick  in  1  pixel enable; x and y are valid on this cycle
x  in  10  current scan column
y  in  10  current scan row
frame_start  in  1  one-cycle pulse at the start of each frame
cmd_valid  in  1  command request
cmd_ready  out  1  command can be accepted
cmd_op  in  2  0 HIDE, 1 SHOW, 2 BLINK, 3 SCROLL
cmd_x  in  10  banner base column
cmd_y  in  10  banner base row
wr_en  in  1  character register write strobe
wr_addr  in  3  slot index
wr_code  in  5  character code; 0 means blank
glyph_start_x  out  32  slot origin column for the renderer
glyph_start_y  out  32  slot origin row for the renderer
glyph_code  out  5  character code of the located slot
glyph_en  out  1  renderer output should be displayed
x_d  out  10  x delayed to align with the glyph outputs
y_d  out  10  y delayed to align with the glyph outputs
banner_active  out  1  state is not HIDE

Behaviour:
Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.

Reset values:
- state HIDE; base_x, base_y = 0.
- All character registers = 0.
- cmd_ready = 1; pending command cleared; frame counter = 0; blink visibility = 1.
- All glyph outputs, x_d, y_d and banner_active = 0.
- Reset asserted mid-frame clears everything immediately.

Command handshake:
- A command is accepted when cmd_valid && cmd_ready. It is latched as pending and cmd_ready drops to 0.
- The pending command is applied on the next frame_start. cmd_ready returns to 1 on the cycle after it is applied.
- If accept coincides with frame_start, the command is applied at the following frame_start, never the coincident one.
- At most one command is pending.

Applying a command:
- Loads base_x = cmd_x and base_y = cmd_y.
- Enters the new state.
- Clears the frame counter and sets blink visibility = 1.

State machine (transitions occur only via applied commands):
- HIDE: glyph_en forced 0.
- SHOW: always visible.
- BLINK: at each frame_start the counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and visibility toggles.
- SCROLL: at each frame_start, if base_x < SCROLL_STEP then base_x = H_RES, else base_x = base_x - SCROLL_STEP.

Character registers:
- wr_en writes code[wr_addr] on the next edge, in any state.
- wr_addr >= NUM_CHARS is ignored.
- A write takes effect from the next lookup.

Lookup (registered, latency 1 cycle after pix_tick):
- rel_x = x - base_x, computed at 11 bits.
- Hit when x >= base_x, rel_x < NUM_CHARS*PITCH, and base_y <= y < base_y + CHAR_H.
- slot = rel_x / PITCH (a shift).
- glyph_start_x = base_x + slot*PITCH; glyph_start_y = base_y (both zero-extended to 32 bits).
- glyph_code = code[slot].
- glyph_en = hit && state != HIDE && visible && code[slot] != 0.
- On a miss: glyph_code = 0 and glyph_en = 0; start outputs hold their last value.
- x_d and y_d register x and y on pix_tick.
- On cycles without pix_tick, all lookup outputs hold.

Clipping:
- Slots extending past column H_RES-1 are clipped naturally by the scan range.
- When frame_start and pix_tick coincide, the lookup uses the pre-update base_x.

Decomposition:
Package pong_text_pkg holds:
- the op encodings HIDE, SHOW, BLINK, SCROLL and the state typedef;
- CHAR_W = 26, CHAR_H, PITCH and H_RES;
- the character-code constants, including BLANK = 0.

Sub-module text_slot_decode is a purely combinational hit/slot/start_x calculator, instantiated once.

Test Plan:
1. After reset, cmd SHOW with cmd_x=100, cmd_y=200 -> cmd_ready=0 until the next frame_start; banner_active=1 on the cycle after that frame_start; cmd_ready=1 one cycle later.
2. code[0]=3, code[1]=0; pix_tick with x=100, y=210 -> next cycle glyph_code=3, glyph_start_x=100, glyph_en=1. With x=133 -> slot 1, glyph_start_x=132, glyph_en=0 (blank). With y=240 -> glyph_en=0.
3. BLINK with BLINK_FRAMES=30 -> glyph_en is 1 for frames 0-29, 0 for frames 30-59, and 1 again at frame 60.
4. SCROLL from cmd_x=3 with SCROLL_STEP=2 -> base_x goes 3, 1, then 640 after successive frame_starts.
5. cmd_valid held with frame_start in the same cycle -> the state is unchanged at that frame and the command is applied at the next one. A second cmd_valid while pending is not accepted.
6. Assert rst_n=0 mid-frame in BLINK -> all outputs 0 immediately, state HIDE, cmd_ready=1 after release.

Source files
------------

// File: rtl/pong_text_pkg.sv
// Shared encodings and geometry for the text banner sequencer.
package pong_text_pkg;

  // Command ops and banner states share one encoding
  typedef enum logic [1:0] {
    HIDE   = 2'd0,
    SHOW   = 2'd1,
    BLINK  = 2'd2,
    SCROLL = 2'd3
  } state_e;

  localparam int CHAR_W = 26;
  localparam int CHAR_H = 40;
  localparam int PITCH  = 32;
  localparam int H_RES  = 640;

  // Character codes understood by the glyph renderer
  localparam logic [4:0] BLANK  = 5'd0;
  localparam logic [4:0] CH_A   = 5'd1;
  localparam logic [4:0] CH_E   = 5'd2;
  localparam logic [4:0] CH_P   = 5'd3;
  localparam logic [4:0] CH_R   = 5'd4;
  localparam logic [4:0] CH_S   = 5'd5;
  localparam logic [4:0] CH_T   = 5'd6;
  localparam logic [4:0] CH_I   = 5'd7;
  localparam logic [4:0] CH_N   = 5'd8;
  localparam logic [4:0] CH_W   = 5'd9;
  localparam logic [4:0] CH_ONE = 5'd10;

endpackage

// File: rtl/text_slot_decode.sv
// Combinational locator: is (x, y) inside the banner, which slot, and where
// that slot starts horizontally.
module text_slot_decode #(
  parameter int NUM_CHARS = 8,
  parameter int CHAR_H    = pong_text_pkg::CHAR_H,
  parameter int PITCH     = pong_text_pkg::PITCH,
  parameter int SLOT_W    = $clog2(NUM_CHARS)
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [9:0]        base_x,
  input  logic [9:0]        base_y,
  output logic              hit,
  output logic [SLOT_W-1:0] slot,
  output logic [10:0]       start_x
);
  import pong_text_pkg::*;

  localparam int          SHIFT    = $clog2(PITCH);
  localparam logic [10:0] SPAN     = 11'(NUM_CHARS * PITCH);
  localparam logic [10:0] HEIGHT   = 11'(CHAR_H);
  localparam logic [10:0] OFF_MASK = ~11'(PITCH - 1);

  logic [10:0] rel_x;
  logic        x_in, y_in;

  // Offset from banner origin; masking the in-slot bits gives slot*PITCH
  assign rel_x   = {1'b0, x} - {1'b0, base_x};
  assign x_in    = (x >= base_x) && (rel_x < SPAN);
  assign y_in    = (y >= base_y) && ({1'b0, y} < ({1'b0, base_y} + HEIGHT));
  assign hit     = x_in && y_in;
  assign slot    = rel_x[SHIFT +: SLOT_W];
  assign start_x = {1'b0, base_x} + (rel_x & OFF_MASK);

endmodule

// File: rtl/text_banner_ctrl.sv
// Text banner sequencer: frame-synchronous command handling, character
// registers and a one-cycle registered slot lookup feeding the glyph renderer.
module text_banner_ctrl #(
  parameter int NUM_CHARS    = 8,
  parameter int CHAR_H       = pong_text_pkg::CHAR_H,
  parameter int PITCH        = pong_text_pkg::PITCH,
  parameter int H_RES        = pong_text_pkg::H_RES,
  parameter int BLINK_FRAMES = 30,
  parameter int SCROLL_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [4:0]  wr_code,
  output logic [31:0] glyph_start_x,
  output logic [31:0] glyph_start_y,
  output logic [4:0]  glyph_code,
  output logic        glyph_en,
  output logic [9:0]  x_d,
  output logic [9:0]  y_d,
  output logic        banner_active
);
  import pong_text_pkg::*;

  localparam int                SLOT_W   = $clog2(NUM_CHARS);
  localparam int                CNT_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [9:0]        STEP     = 10'(SCROLL_STEP);
  localparam logic [9:0]        WRAP     = 10'(H_RES);

  state_e            state_q, state_d;
  logic              pend_q, ready_q;
  logic [1:0]        pend_op_q;
  logic [9:0]        pend_x_q, pend_y_q;
  logic [9:0]        base_x_q, base_y_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              vis_q;
  logic [4:0]        code_q [NUM_CHARS];
  logic              accept, apply, show_en;

  logic              hit;
  logic [SLOT_W-1:0] slot;
  logic [10:0]       slot_x;

  logic [31:0]       start_x_q, start_y_q;
  logic [4:0]        gcode_q;
  logic              gen_q;
  logic [9:0]        x_q, y_q;

  // ready implies nothing pending, so accept and apply never coincide
  assign accept = cmd_valid && ready_q;
  assign apply  = pend_q && frame_start;

  // Single-entry command holding register; ready returns one cycle after apply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      ready_q   <= 1'b1;
      pend_op_q <= 2'd0;
      pend_x_q  <= 10'd0;
      pend_y_q  <= 10'd0;
    end else if (accept) begin
      pend_q    <= 1'b1;
      ready_q   <= 1'b0;
      pend_op_q <= cmd_op;
      pend_x_q  <= cmd_x;
      pend_y_q  <= cmd_y;
    end else if (apply) begin
      pend_q    <= 1'b0;
    end else if (!pend_q && !ready_q) begin
      ready_q   <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HIDE;
    else        state_q <= state_d;
  end

  // FSM next state: only an applied command changes mode
  always_comb begin
    state_d = state_q;
    if (apply) state_d = state_e'(pend_op_q);
  end

  // FSM outputs
  always_comb begin
    banner_active = (state_q != HIDE);
    show_en       = (state_q != HIDE) && vis_q;
  end

  // Banner origin, blink counter and visibility, all advanced on frame_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_x_q <= 10'd0;
      base_y_q <= 10'd0;
      cnt_q    <= '0;
      vis_q    <= 1'b1;
    end else if (apply) begin
      base_x_q <= pend_x_q;
      base_y_q <= pend_y_q;
      cnt_q    <= '0;
      vis_q    <= 1'b1;
    end else if (frame_start) begin
      if (state_q == BLINK) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          vis_q <= ~vis_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (state_q == SCROLL) begin
        base_x_q <= (base_x_q < STEP) ? WRAP : (base_x_q - STEP);
      end
    end
  end

  // Character registers; out-of-range addresses are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) code_q[i] <= BLANK;
    end else if (wr_en && (32'(wr_addr) < NUM_CHARS)) begin
      code_q[wr_addr[SLOT_W-1:0]] <= wr_code;
    end
  end

  text_slot_decode #(
    .NUM_CHARS (NUM_CHARS),
    .CHAR_H    (CHAR_H),
    .PITCH     (PITCH),
    .SLOT_W    (SLOT_W)
  ) u_decode (
    .x       (x),
    .y       (y),
    .base_x  (base_x_q),
    .base_y  (base_y_q),
    .hit     (hit),
    .slot    (slot),
    .start_x (slot_x)
  );

  // Registered lookup; start coordinates keep their last value on a miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_x_q <= 32'd0;
      start_y_q <= 32'd0;
      gcode_q   <= BLANK;
      gen_q     <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
    end else if (pix_tick) begin
      x_q <= x;
      y_q <= y;
      if (hit) begin
        start_x_q <= {21'd0, slot_x};
        start_y_q <= {22'd0, base_y_q};
        gcode_q   <= code_q[slot];
        gen_q     <= show_en && (code_q[slot] != BLANK);
      end else begin
        gcode_q   <= BLANK;
        gen_q     <= 1'b0;
      end
    end
  end

  assign cmd_ready     = ready_q;
  assign glyph_start_x = start_x_q;
  assign glyph_start_y = start_y_q;
  assign glyph_code    = gcode_q;
  assign glyph_en      = gen_q;
  assign x_d           = x_q;
  assign y_d           = y_q;

endmodule

// File: tb/tb_text_banner_ctrl.sv
// Directed bench for text_banner_ctrl.
module tb_text_banner_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_tick, frame_start, cmd_valid, wr_en;
  logic [9:0]  x, y, cmd_x, cmd_y;
  logic [1:0]  cmd_op;
  logic [2:0]  wr_addr;
  logic [4:0]  wr_code;
  logic        cmd_ready, glyph_en, banner_active;
  logic [31:0] glyph_start_x, glyph_start_y;
  logic [4:0]  glyph_code;
  logic [9:0]  x_d, y_d;

  int checks = 0;
  int errors = 0;

  text_banner_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .x(x), .y(y),
    .frame_start(frame_start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_code(wr_code), .glyph_start_x(glyph_start_x),
    .glyph_start_y(glyph_start_y), .glyph_code(glyph_code), .glyph_en(glyph_en),
    .x_d(x_d), .y_d(y_d), .banner_active(banner_active)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: each is entered and left 1 time unit after a rising edge
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic frame();
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py);
    pix_tick = 1'b1; x = px; y = py; cycle(); pix_tick = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [9:0] cx, input logic [9:0] cy);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = cx; cmd_y = cy; cycle(); cmd_valid = 1'b0;
  endtask

  task automatic write_code(input logic [2:0] a, input logic [4:0] c);
    wr_en = 1'b1; wr_addr = a; wr_code = c; cycle(); wr_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", cmd_ready); end
    checks++; if (banner_active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b exp 0", banner_active); end
    checks++; if (glyph_en !== 1'b0 || glyph_code !== 5'd0) begin errors++; $display("FAIL reset_glyph got en=%0b code=%0d exp 0/0", glyph_en, glyph_code); end
    checks++; if (glyph_start_x !== 32'd0 || glyph_start_y !== 32'd0 || x_d !== 10'd0 || y_d !== 10'd0) begin
      errors++; $display("FAIL reset_coords got sx=%0d sy=%0d xd=%0d yd=%0d exp all 0", glyph_start_x, glyph_start_y, x_d, y_d); end
  endtask

  task automatic test_show_handshake();
    send_cmd(2'd1, 10'd100, 10'd200);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_drop got %0b exp 0", cmd_ready); end
    cycle(); cycle();
    checks++; if (cmd_ready !== 1'b0 || banner_active !== 1'b0) begin errors++; $display("FAIL hs_wait got ready=%0b active=%0b exp 0/0", cmd_ready, banner_active); end
    frame();
    checks++; if (banner_active !== 1'b1) begin errors++; $display("FAIL hs_active got %0b exp 1", banner_active); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_apply got %0b exp 0", cmd_ready); end
    cycle();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_back got %0b exp 1", cmd_ready); end
  endtask

  task automatic test_lookup();
    write_code(3'd0, 5'd3);
    write_code(3'd1, 5'd0);
    pix(10'd100, 10'd210);
    checks++; if (glyph_code !== 5'd3 || glyph_en !== 1'b1) begin errors++; $display("FAIL lk_slot0 got code=%0d en=%0b exp 3/1", glyph_code, glyph_en); end
    checks++; if (glyph_start_x !== 32'd100 || glyph_start_y !== 32'd200) begin errors++; $display("FAIL lk_start0 got %0d,%0d exp 100,200", glyph_start_x, glyph_start_y); end
    checks++; if (x_d !== 10'd100 || y_d !== 10'd210) begin errors++; $display("FAIL lk_xyd got %0d,%0d exp 100,210", x_d, y_d); end
    pix(10'd133, 10'd210);
    checks++; if (glyph_start_x !== 32'd132 || glyph_en !== 1'b0 || glyph_code !== 5'd0) begin
      errors++; $display("FAIL lk_slot1_blank got sx=%0d en=%0b code=%0d exp 132/0/0", glyph_start_x, glyph_en, glyph_code); end
    pix(10'd100, 10'd240);
    checks++; if (glyph_en !== 1'b0 || glyph_code !== 5'd0 || glyph_start_x !== 32'd132) begin
      errors++; $display("FAIL lk_below got en=%0b code=%0d sx=%0d exp 0/0/132", glyph_en, glyph_code, glyph_start_x); end
    pix(10'd100, 10'd239);
    checks++; if (glyph_en !== 1'b1 || glyph_start_x !== 32'd100) begin errors++; $display("FAIL lk_lastrow got en=%0b sx=%0d exp 1/100", glyph_en, glyph_start_x); end
    pix(10'd99, 10'd210);
    checks++; if (glyph_en !== 1'b0 || glyph_code !== 5'd0) begin errors++; $display("FAIL lk_left got en=%0b code=%0d exp 0/0", glyph_en, glyph_code); end
    pix(10'd356, 10'd210);
    checks++; if (glyph_en !== 1'b0 || glyph_code !== 5'd0) begin errors++; $display("FAIL lk_right got en=%0b code=%0d exp 0/0", glyph_en, glyph_code); end
    write_code(3'd7, 5'd9);
    pix(10'd355, 10'd210);
    checks++; if (glyph_code !== 5'd9 || glyph_start_x !== 32'd324 || glyph_en !== 1'b1) begin
      errors++; $display("FAIL lk_slot7 got code=%0d sx=%0d en=%0b exp 9/324/1", glyph_code, glyph_start_x, glyph_en); end
    x = 10'd5; y = 10'd6; cycle(); cycle();
    checks++; if (x_d !== 10'd355 || y_d !== 10'd210 || glyph_code !== 5'd9) begin
      errors++; $display("FAIL lk_hold got xd=%0d yd=%0d code=%0d exp 355/210/9", x_d, y_d, glyph_code); end
  endtask

  task automatic test_blink();
    logic exp_en;
    send_cmd(2'd2, 10'd100, 10'd200);
    for (int f = 0; f <= 60; f++) begin
      frame();
      pix(10'd100, 10'd210);
      exp_en = (f < 30) || (f >= 60);
      checks++; if (glyph_en !== exp_en) begin errors++; $display("FAIL blink_f%0d got %0b exp %0b", f, glyph_en, exp_en); end
    end
  endtask

  task automatic test_scroll();
    cycle();
    send_cmd(2'd3, 10'd3, 10'd200);
    frame();
    pix(10'd3, 10'd210);
    checks++; if (glyph_start_x !== 32'd3 || glyph_en !== 1'b1) begin errors++; $display("FAIL scroll_b3 got sx=%0d en=%0b exp 3/1", glyph_start_x, glyph_en); end
    frame();
    pix(10'd1, 10'd210);
    checks++; if (glyph_start_x !== 32'd1 || glyph_en !== 1'b1) begin errors++; $display("FAIL scroll_b1 got sx=%0d en=%0b exp 1/1", glyph_start_x, glyph_en); end
    frame();
    pix(10'd1, 10'd210);
    checks++; if (glyph_en !== 1'b0 || glyph_code !== 5'd0) begin errors++; $display("FAIL scroll_old got en=%0b code=%0d exp 0/0", glyph_en, glyph_code); end
    pix(10'd640, 10'd210);
    checks++; if (glyph_start_x !== 32'd640 || glyph_code !== 5'd3) begin errors++; $display("FAIL scroll_wrap got sx=%0d code=%0d exp 640/3", glyph_start_x, glyph_code); end
  endtask

  task automatic test_back_to_back();
    cycle(); cycle();
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_x = 10'd50; cmd_y = 10'd200; frame_start = 1'b1;
    cycle();
    cmd_valid = 1'b0; frame_start = 1'b0;
    checks++; if (banner_active !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_coincide got active=%0b ready=%0b exp 1/0", banner_active, cmd_ready); end
    pix(10'd638, 10'd210);
    checks++; if (glyph_start_x !== 32'd638 || glyph_en !== 1'b1) begin errors++; $display("FAIL b2b_scrolled got sx=%0d en=%0b exp 638/1", glyph_start_x, glyph_en); end
    send_cmd(2'd1, 10'd10, 10'd200);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_ready got %0b exp 0", cmd_ready); end
    frame();
    checks++; if (banner_active !== 1'b0) begin errors++; $display("FAIL b2b_applied got %0b exp 0", banner_active); end
    cycle();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got %0b exp 1", cmd_ready); end
    frame();
    checks++; if (banner_active !== 1'b0) begin errors++; $display("FAIL b2b_no_second got %0b exp 0", banner_active); end
    pix(10'd50, 10'd210);
    checks++; if (glyph_start_x !== 32'd50 || glyph_code !== 5'd3 || glyph_en !== 1'b0) begin
      errors++; $display("FAIL b2b_hide got sx=%0d code=%0d en=%0b exp 50/3/0", glyph_start_x, glyph_code, glyph_en); end
  endtask

  task automatic test_reset_midframe();
    send_cmd(2'd2, 10'd100, 10'd200);
    frame();
    cycle();
    frame();
    pix(10'd100, 10'd210);
    checks++; if (glyph_en !== 1'b1 || banner_active !== 1'b1) begin errors++; $display("FAIL rst_pre got en=%0b active=%0b exp 1/1", glyph_en, banner_active); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (glyph_en !== 1'b0 || glyph_code !== 5'd0 || banner_active !== 1'b0) begin
      errors++; $display("FAIL rst_async got en=%0b code=%0d active=%0b exp 0/0/0", glyph_en, glyph_code, banner_active); end
    checks++; if (glyph_start_x !== 32'd0 || glyph_start_y !== 32'd0 || x_d !== 10'd0 || y_d !== 10'd0) begin
      errors++; $display("FAIL rst_coords got sx=%0d sy=%0d xd=%0d yd=%0d exp 0", glyph_start_x, glyph_start_y, x_d, y_d); end
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++; if (cmd_ready !== 1'b1 || banner_active !== 1'b0) begin errors++; $display("FAIL rst_release got ready=%0b active=%0b exp 1/0", cmd_ready, banner_active); end
    send_cmd(2'd1, 10'd100, 10'd200);
    frame();
    pix(10'd100, 10'd210);
    checks++; if (glyph_code !== 5'd0 || glyph_en !== 1'b0 || glyph_start_x !== 32'd100) begin
      errors++; $display("FAIL rst_codes got code=%0d en=%0b sx=%0d exp 0/0/100", glyph_code, glyph_en, glyph_start_x); end
  endtask

  initial begin
    rst_n = 1'b0; pix_tick = 1'b0; frame_start = 1'b0; cmd_valid = 1'b0; wr_en = 1'b0;
    x = '0; y = '0; cmd_x = '0; cmd_y = '0; cmd_op = '0; wr_addr = '0; wr_code = '0;
    cycle(); cycle();
    test_reset();
    rst_n = 1'b1;
    cycle();
    test_reset();
    test_show_handshake();
    test_lookup();
    test_blink();
    test_scroll();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
